fp_addsub_seq: RTL and testbench

- Parametrised, multi-cycle sign-magnitude floating-point add/subtract unit with valid/ready handshakes on input and output.
- Next generation of the combinational float adder. Adds configurable mantissa and exponent widths, serial alignment and normalisation (one bit per cycle), output back-pressure, and overflow, underflow and zero flags.
- Sits between operand registers and the result writeback.

---
 rtl/fp_addsub_seq_if.sv | 34 +++
 rtl/fp_addsub_seq.sv | 163 ++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_seq_if.sv
// Operand/result handshake bundle for the sequential float add/subtract unit.
// The slave side belongs to the unit; the master side belongs to the producer/consumer.
interface fp_addsub_seq_if #(
  parameter int MANT_W = 11,
  parameter int EXP_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] inp1;
  logic              sgn1;
  logic [EXP_W-1:0]  exp1;
  logic [MANT_W-1:0] inp2;
  logic              sgn2;
  logic [EXP_W-1:0]  exp2;
  logic              operatin;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out;
  logic              sgnout;
  logic [EXP_W-1:0]  outexp;
  logic              flag_zero;
  logic              flag_ovf;
  logic              flag_udf;

  modport master (
    output in_valid, inp1, sgn1, exp1, inp2, sgn2, exp2, operatin, out_ready,
    input  in_ready, out_valid, out, sgnout, outexp, flag_zero, flag_ovf, flag_udf
  );

  modport slave (
    input  in_valid, inp1, sgn1, exp1, inp2, sgn2, exp2, operatin, out_ready,
    output in_ready, out_valid, out, sgnout, outexp, flag_zero, flag_ovf, flag_udf
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle sign-magnitude float add/subtract: serial alignment and normalisation,
// one bit per cycle, with valid/ready on both sides and zero/overflow/underflow flags.
module fp_addsub_seq #(
  parameter int MANT_W = 11,
  parameter int EXP_W  = 5
) (
  input logic            clk,
  input logic            rst,
  fp_addsub_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  state_t            state;
  logic [MANT_W-1:0] mant_a, mant_b;
  logic [EXP_W-1:0]  exp_a, diff;
  logic              sgn_a, eff_sub;
  logic [MANT_W:0]   sum;

  logic              in_ready_q, out_valid_q, sgnout_q;
  logic              zero_q, ovf_q, udf_q;
  logic [MANT_W-1:0] out_q;
  logic [EXP_W-1:0]  outexp_q;

  // A zero mantissa orders as exponent 0 so it can never be the larger operand.
  logic [EXP_W-1:0] e1, e2;
  logic             s2_eff, swap;
  assign e1     = (bus.inp1 == '0) ? '0 : bus.exp1;
  assign e2     = (bus.inp2 == '0) ? '0 : bus.exp2;
  assign s2_eff = bus.sgn2 ^ bus.operatin;
  assign swap   = {e1, bus.inp1} < {e2, bus.inp2};

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.sgnout    = sgnout_q;
  assign bus.outexp    = outexp_q;
  assign bus.flag_zero = zero_q;
  assign bus.flag_ovf  = ovf_q;
  assign bus.flag_udf  = udf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mant_a      <= '0;
      mant_b      <= '0;
      exp_a       <= '0;
      diff        <= '0;
      sgn_a       <= 1'b0;
      eff_sub     <= 1'b0;
      sum         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sgnout_q    <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      out_q       <= '0;
      outexp_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready_q && bus.in_valid) begin
            if (swap) begin
              mant_a <= bus.inp2;
              exp_a  <= e2;
              sgn_a  <= s2_eff;
              mant_b <= bus.inp1;
              diff   <= e2 - e1;
            end else begin
              mant_a <= bus.inp1;
              exp_a  <= e1;
              sgn_a  <= bus.sgn1;
              mant_b <= bus.inp2;
              diff   <= e1 - e2;
            end
            eff_sub    <= bus.sgn1 ^ s2_eff;
            in_ready_q <= 1'b0;
            state      <= ALIGN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end

        // Far-apart exponents take a two-cycle shortcut instead of shifting B to zero.
        ALIGN: begin
          if (diff == '0) begin
            state <= ADD;
          end else if (32'(diff) > MANT_W) begin
            mant_b <= '0;
            diff   <= '0;
          end else begin
            mant_b <= mant_b >> 1;
            diff   <= diff - 1'b1;
          end
        end

        ADD: begin
          if (eff_sub)
            sum <= {1'b0, mant_a} - {1'b0, mant_b};
          else
            sum <= {1'b0, mant_a} + {1'b0, mant_b};
          state <= NORM;
        end

        NORM: begin
          if (sum[MANT_W]) begin
            if (exp_a == EXP_MAX) begin
              out_q    <= '1;
              outexp_q <= '1;
              ovf_q    <= 1'b1;
            end else begin
              out_q    <= sum[MANT_W:1];
              outexp_q <= exp_a + 1'b1;
            end
            sgnout_q    <= sgn_a;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else if (sum == '0) begin
            out_q       <= '0;
            outexp_q    <= '0;
            sgnout_q    <= 1'b0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else if (sum[MANT_W-1]) begin
            out_q       <= sum[MANT_W-1:0];
            outexp_q    <= exp_a;
            sgnout_q    <= sgn_a;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else if (exp_a == '0) begin
            // No exponent left to borrow from: flush the denormal result to zero.
            out_q       <= '0;
            outexp_q    <= '0;
            sgnout_q    <= 1'b0;
            zero_q      <= 1'b1;
            udf_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            sum   <= sum << 1;
            exp_a <= exp_a - 1'b1;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq: directed cases with hand-derived results,
// back-pressure and mid-operation reset, then random operands against an arithmetic model.
module tb_fp_addsub_seq;
  localparam int MANT_W = 11;
  localparam int EXP_W  = 5;
  localparam int EMAX   = (1 << EXP_W) - 1;

  typedef struct {
    int m; int e; int s; int z; int ovf; int udf; int lat;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fp_addsub_seq_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) bus ();

  fp_addsub_seq #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic res_t mk(input int m, e, s, z, ovf, udf, lat);
    res_t r;
    r.m = m; r.e = e; r.s = s; r.z = z; r.ovf = ovf; r.udf = udf; r.lat = lat;
    return r;
  endfunction

  // Value-level reference: order by magnitude, truncate the smaller operand, then
  // renormalise one step at a time, counting cycles the way the latency rule states.
  function automatic res_t model(input int m1, e1, s1, m2, e2, s2, op);
    res_t r;
    int top, half, ea, eb, sb, ma, xa, sa, mb, xb, d, sum, ex, na, nn;
    bit sub, fin;
    top  = 1 << MANT_W;
    half = 1 << (MANT_W - 1);
    r    = mk(0, 0, 0, 0, 0, 0, 0);
    ea   = (m1 == 0) ? 0 : e1;
    eb   = (m2 == 0) ? 0 : e2;
    sb   = s2 ^ op;
    if (ea * top + m1 >= eb * top + m2) begin
      ma = m1; xa = ea; sa = s1; mb = m2; xb = eb;
    end else begin
      ma = m2; xa = eb; sa = sb; mb = m1; xb = ea;
    end
    sub = (s1 ^ sb) != 0;
    d   = xa - xb;
    na  = (d <= MANT_W) ? d + 1 : 2;
    mb  = (d > MANT_W) ? 0 : (mb >> d);
    sum = sub ? ma - mb : ma + mb;
    ex  = xa;
    nn  = 0;
    fin = 1'b0;
    while (!fin) begin
      nn++;
      if (sum >= top) begin
        if (ex == EMAX) begin
          r.m = top - 1; r.e = EMAX; r.ovf = 1;
        end else begin
          r.m = sum / 2; r.e = ex + 1;
        end
        r.s = sa; fin = 1'b1;
      end else if (sum == 0) begin
        r.z = 1; fin = 1'b1;
      end else if (sum >= half) begin
        r.m = sum; r.e = ex; r.s = sa; fin = 1'b1;
      end else if (ex == 0) begin
        r.z = 1; r.udf = 1; fin = 1'b1;
      end else begin
        sum = sum * 2; ex = ex - 1;
      end
    end
    r.lat = na + nn + 2;
    return r;
  endfunction

  function automatic logic [31:0] packObs();
    return 32'({bus.out_valid, bus.in_ready, bus.flag_zero, bus.flag_ovf, bus.flag_udf,
                bus.sgnout, bus.outexp, bus.out});
  endfunction

  function automatic logic [31:0] packExp(input res_t r);
    logic [MANT_W-1:0] m;
    logic [EXP_W-1:0]  e;
    m = r.m[MANT_W-1:0];
    e = r.e[EXP_W-1:0];
    return 32'({1'b1, 1'b0, r.z[0], r.ovf[0], r.udf[0], r.s[0], e, m});
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Called at a falling edge; returns the edge number (capture = 1) where out_valid rose.
  task automatic applyStimulus(input int m1, e1, s1, m2, e2, s2, op, output int edges);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkValue("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.inp1     = m1[MANT_W-1:0];
    bus.exp1     = e1[EXP_W-1:0];
    bus.sgn1     = s1[0];
    bus.inp2     = m2[MANT_W-1:0];
    bus.exp2     = e2[EXP_W-1:0];
    bus.sgn2     = s2[0];
    bus.operatin = op[0];
    bus.in_valid = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (bus.out_valid !== 1'b1 && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string tag, input res_t r, input int edges);
    checkValue({tag, "_latency"}, 32'(edges), 32'(r.lat));
    checkValue({tag, "_result"}, packObs(), packExp(r));
  endtask

  task automatic releaseResult(input res_t r, input int hold, input bit poke);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.in_valid = (i % 2 == 0);
        bus.inp1     = MANT_W'($urandom);
        bus.exp1     = EXP_W'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      checkValue("hold_stable", packObs(), packExp(r));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkValue("after_handshake",
               32'({bus.out_valid, bus.in_ready, bus.flag_zero, bus.flag_ovf, bus.flag_udf}),
               32'(5'b01000));
  endtask

  task automatic runDirected(input string tag, input int m1, e1, s1, m2, e2, s2, op,
                             input res_t want, input int hold, input bit poke);
    int edges;
    applyStimulus(m1, e1, s1, m2, e2, s2, op, edges);
    checkOutput(tag, want, edges);
    releaseResult(want, hold, poke);
  endtask

  initial begin
    int   edges, m1, e1, s1, m2, e2, s2, op;
    bit   sawValid;
    res_t r;

    $display("[TB] fp_addsub_seq bench starting");
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.operatin = 1'b0;
    bus.inp1 = '0; bus.exp1 = '0; bus.sgn1 = 1'b0;
    bus.inp2 = '0; bus.exp2 = '0; bus.sgn2 = 1'b0;

    repeat (3) @(negedge clk);
    checkValue("reset_state", packObs(), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkValue("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    runDirected("eq_carry",   'h400, 5, 0, 'h400, 5, 0, 0, mk('h400, 6, 0, 0, 0, 0, 4), 0, 0);
    runDirected("cancel",     'h600, 3, 0, 'h400, 3, 0, 1, mk('h400, 2, 0, 0, 0, 0, 5), 1, 0);
    runDirected("exact_zero", 'h400, 4, 0, 'h400, 4, 0, 1, mk(0, 0, 0, 1, 0, 0, 4), 0, 0);
    runDirected("align_swap", 'h400, 3, 0, 'h400, 5, 0, 0, mk('h500, 5, 0, 0, 0, 0, 6), 0, 0);
    runDirected("shortcut",   'h400, 1, 0, 'h400, 21, 1, 0, mk('h400, 21, 1, 0, 0, 0, 5), 0, 0);
    runDirected("overflow",   'h400, 31, 0, 'h400, 31, 0, 0, mk('h7FF, 31, 0, 0, 1, 0, 4), 0, 0);
    runDirected("underflow",  'h401, 0, 0, 'h400, 0, 0, 1, mk(0, 0, 0, 1, 0, 1, 4), 0, 0);
    runDirected("zero_zero",  0, 7, 1, 0, 3, 0, 1, mk(0, 0, 0, 1, 0, 0, 4), 0, 0);
    runDirected("zero_pass",  0, 9, 0, 'h500, 4, 0, 1, mk('h500, 4, 1, 0, 0, 0, 8), 0, 0);
    runDirected("backpress",  'h600, 10, 0, 'h500, 8, 0, 0, mk('h740, 10, 0, 0, 0, 0, 6), 5, 1);

    // Abort an operation mid-alignment (diff = 8) with an asynchronous reset.
    bus.inp1 = 'h400; bus.exp1 = 10; bus.sgn1 = 1'b0;
    bus.inp2 = 'h400; bus.exp2 = 2;  bus.sgn2 = 1'b0;
    bus.operatin = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkValue("async_reset_outputs", packObs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sawValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkValue("in_ready_after_abort", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      sawValid |= (bus.out_valid === 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    checkValue("no_valid_after_abort", 32'(sawValid), 32'd0);
    runDirected("after_abort", 'h400, 10, 0, 'h400, 2, 0, 0, mk('h404, 10, 0, 0, 0, 0, 12), 0, 0);

    for (int i = 0; i < 60; i++) begin
      m1 = ($urandom_range(0, 7) == 0) ? 0 : ((1 << (MANT_W - 1)) | int'($urandom_range(0, (1 << (MANT_W - 1)) - 1)));
      m2 = ($urandom_range(0, 7) == 0) ? 0 : ((1 << (MANT_W - 1)) | int'($urandom_range(0, (1 << (MANT_W - 1)) - 1)));
      e1 = int'($urandom_range(0, EMAX));
      e2 = ($urandom_range(0, 1) == 0) ? (e1 ^ int'($urandom_range(0, 3))) : int'($urandom_range(0, EMAX));
      s1 = int'($urandom_range(0, 1));
      s2 = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 1));
      r  = model(m1, e1, s1, m2, e2, s2, op);
      applyStimulus(m1, e1, s1, m2, e2, s2, op, edges);
      checkOutput("random", r, edges);
      releaseResult(r, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
